// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 command bytes, FSM encodings and parameter defaults for lcd_msg_driver
package lcd_pkg;
  localparam int PWRUP_CYCLES_DEF   = 20;
  localparam int CLR_CYCLES_DEF     = 2;
  localparam int TIMEOUT_CYCLES_DEF = 63;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  typedef enum logic [2:0] {PWRUP, INIT, CLRWAIT, REFRESH_RUN, IDLE, ERROR} state_t;
  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_WAIT} xfer_state_t;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC_SET : i == 2'd1 ? CMD_DISP_ON : i == 2'd2 ? CMD_CLEAR : CMD_ENTRY;
  endfunction
endpackage

// File: rtl/lcd_xfer.sv
// lcd_xfer: one-byte START/DONE handshake to the LCD byte-writer with DONE edge detect and timeout.
//   CLK1K, RSTN         clock, async active-low reset
//   req, data_in, rs_in transfer request; byte and RS sampled in the cycle req is accepted
//   DONE_IN             writer done flag (only a 0->1 edge while waiting completes)
//   DATA_OUT, RS_OUT    byte/RS held from acceptance until completion
//   START_OUT           rises one cycle after DATA_OUT/RS_OUT are loaded
//   ack, timeout        single-cycle completion / expiry pulses
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       req,
  input  logic [7:0] data_in,
  input  logic       rs_in,
  input  logic       DONE_IN,
  output logic [7:0] DATA_OUT,
  output logic       RS_OUT,
  output logic       START_OUT,
  output logic       ack,
  output logic       timeout
);
  xfer_state_t st, st_nx;
  logic [15:0] tcnt;
  logic done_q, done_rise;
  always_comb begin
    done_rise = DONE_IN && !done_q;
    ack = st == X_WAIT && done_rise;
    timeout = st == X_WAIT && !done_rise && tcnt == 16'(TIMEOUT_CYCLES - 1);
    st_nx = st == X_IDLE ? (req ? X_SETUP : X_IDLE) :
            st == X_SETUP ? X_WAIT :
            (ack || timeout) ? X_IDLE : X_WAIT;
  end
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      st <= X_IDLE;
      tcnt <= '0;
      done_q <= 1'b0;
      DATA_OUT <= '0;
      RS_OUT <= 1'b0;
      START_OUT <= 1'b0;
    end else begin
      st <= st_nx;
      done_q <= DONE_IN;
      // counter restarts on the cycle START rises, so expiry lands exactly TIMEOUT_CYCLES later
      tcnt <= st == X_WAIT ? tcnt + 16'd1 : '0;
      START_OUT <= st_nx == X_WAIT;
      if (st == X_IDLE && req) begin
        DATA_OUT <= data_in;
        RS_OUT <= rs_in;
      end
    end
  end
endmodule

// File: rtl/lcd_msg_driver.sv
// lcd_msg_driver: HD44780 power-up/init sequencer and 2x16 message refresher over a byte-writer.
//   CLK1K, RSTN        1 kHz clock, async active-low reset
//   REFRESH            rising edge requests a 32-character rewrite
//   CHAR_DATA/CHAR_IDX combinational character source and its index 0..31
//   DATA_OUT, RS_OUT   byte and command(0)/data(1) select to the writer
//   START_OUT, DONE_IN transfer handshake with the writer
//   READY              idle with no pending refresh
//   ERR_OUT            sticky writer timeout
module lcd_msg_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES   = PWRUP_CYCLES_DEF,
  parameter int CLR_CYCLES     = CLR_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       REFRESH,
  input  logic [7:0] CHAR_DATA,
  output logic [4:0] CHAR_IDX,
  output logic [7:0] DATA_OUT,
  output logic       RS_OUT,
  output logic       START_OUT,
  input  logic       DONE_IN,
  output logic       READY,
  output logic       ERR_OUT
);
  state_t st, st_nx;
  logic [15:0] cnt, cnt_nx;
  logic [5:0] step, step_nx;
  logic [4:0] idx_nx;
  logic pending, pending_nx, refresh_q, rise, char_step, req, rs_sel, ack, timeout;
  logic [7:0] byte_sel;
  lcd_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
    .CLK1K(CLK1K),
    .RSTN(RSTN),
    .req(req),
    .data_in(byte_sel),
    .rs_in(rs_sel),
    .DONE_IN(DONE_IN),
    .DATA_OUT(DATA_OUT),
    .RS_OUT(RS_OUT),
    .START_OUT(START_OUT),
    .ack(ack),
    .timeout(timeout)
  );
  assign READY = st == IDLE && !pending;
  assign ERR_OUT = st == ERROR;
  // refresh steps: 0 = line-1 address, 1..16 chars 0..15, 17 = line-2 address, 18..33 chars 16..31
  always_comb begin
    rise = REFRESH && !refresh_q;
    char_step = step != 6'd0 && step != 6'd17;
    req = st == INIT || st == REFRESH_RUN;
    rs_sel = st == REFRESH_RUN && char_step;
    byte_sel = st == INIT ? init_cmd(step[1:0]) : step == 6'd0 ? CMD_LINE1 : step == 6'd17 ? CMD_LINE2 : CHAR_DATA;
    st_nx = st;
    cnt_nx = cnt;
    step_nx = step;
    idx_nx = CHAR_IDX;
    pending_nx = pending || (rise && st != IDLE && st != ERROR);
    case (st)
      PWRUP:
        if (int'(cnt) + 1 >= PWRUP_CYCLES) begin
          st_nx = INIT;
          cnt_nx = '0;
          step_nx = '0;
        end else cnt_nx = cnt + 16'd1;
      INIT:
        if (timeout) st_nx = ERROR;
        else if (ack) begin
          step_nx = step == 6'd3 ? 6'd0 : step + 6'd1;
          st_nx = step == 6'd2 ? CLRWAIT : step == 6'd3 ? REFRESH_RUN : INIT;
          // the automatic refresh already covers requests made during init
          pending_nx = step == 6'd3 ? 1'b0 : pending_nx;
        end
      CLRWAIT:
        if (int'(cnt) + 1 >= CLR_CYCLES) begin
          st_nx = INIT;
          cnt_nx = '0;
        end else cnt_nx = cnt + 16'd1;
      REFRESH_RUN:
        if (timeout) st_nx = ERROR;
        else if (ack) begin
          idx_nx = char_step ? CHAR_IDX + 5'd1 : CHAR_IDX;
          step_nx = step == 6'd33 ? 6'd0 : step + 6'd1;
          st_nx = step == 6'd33 && !pending_nx ? IDLE : REFRESH_RUN;
          pending_nx = step == 6'd33 ? 1'b0 : pending_nx;
        end
      IDLE:
        if (rise) begin
          st_nx = REFRESH_RUN;
          step_nx = '0;
        end
      default: ;
    endcase
  end
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      st <= PWRUP;
      cnt <= '0;
      step <= '0;
      CHAR_IDX <= '0;
      pending <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      step <= step_nx;
      CHAR_IDX <= idx_nx;
      pending <= pending_nx;
      refresh_q <= REFRESH;
    end
  end
endmodule

// File: tb/tb_lcd_msg_driver.sv
// tb_lcd_msg_driver: directed bench for lcd_msg_driver with a writer model and transfer log
module tb_lcd_msg_driver;
  logic CLK1K = 1'b0, RSTN = 1'b0, REFRESH = 1'b0, DONE_IN = 1'b0;
  logic [7:0] CHAR_DATA, DATA_OUT;
  logic [4:0] CHAR_IDX;
  logic RS_OUT, START_OUT, READY, ERR_OUT;
  lcd_msg_driver dut (
    .CLK1K(CLK1K),
    .RSTN(RSTN),
    .REFRESH(REFRESH),
    .CHAR_DATA(CHAR_DATA),
    .CHAR_IDX(CHAR_IDX),
    .DATA_OUT(DATA_OUT),
    .RS_OUT(RS_OUT),
    .START_OUT(START_OUT),
    .DONE_IN(DONE_IN),
    .READY(READY),
    .ERR_OUT(ERR_OUT)
  );
  always #5 CLK1K = ~CLK1K;
  // character source scrambles itself while START is high, so a late capture shows up as wrong data
  assign CHAR_DATA = (8'h41 + {3'b000, CHAR_IDX}) ^ {8{START_OUT}};

  typedef struct {
    logic [7:0] data;
    logic       rs;
  } vec_t;
  vec_t exp_tab[38];

  int errors = 0, checks = 0, cyc = 0, rel = 0, stab_err = 0;
  logic [8:0] log_q[$];
  int rise_q[$], fall_q[$];
  logic start_prev = 1'b0;
  logic [8:0] prev_bus = '0, held = '0;
  int wcnt = 0, wn = 0, hold_n = 0, skip_n = 0;
  logic w_prev = 1'b0;

  always @(posedge CLK1K) cyc++;

  always @(negedge CLK1K) begin
    if (START_OUT && !start_prev) begin
      log_q.push_back({RS_OUT, DATA_OUT});
      rise_q.push_back(cyc);
      if ({RS_OUT, DATA_OUT} != prev_bus) stab_err++;
      held = {RS_OUT, DATA_OUT};
    end
    if (START_OUT && {RS_OUT, DATA_OUT} != held) stab_err++;
    if (!START_OUT && start_prev) fall_q.push_back(cyc);
    prev_bus = {RS_OUT, DATA_OUT};
    start_prev = START_OUT;
  end

  // writer: DONE cleared on START rise (except the held transfer), raised 19 cycles later
  always @(negedge CLK1K) begin
    if (!RSTN) begin
      DONE_IN = 1'b0;
      wcnt = 0;
      wn = 0;
      w_prev = 1'b0;
    end else begin
      if (START_OUT && !w_prev) begin
        wn++;
        wcnt = 1;
        if (wn != hold_n) DONE_IN = 1'b0;
      end else if (START_OUT) wcnt++;
      if (START_OUT && wn == hold_n && wcnt == 6) DONE_IN = 1'b0;
      if (START_OUT && wcnt == 19 && wn != skip_n) DONE_IN = 1'b1;
      w_prev = START_OUT;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
    end
  endtask

  task automatic cmp(input int lo, input int n, input int elo, input string nm);
    for (int i = 0; i < n; i++) begin
      logic [31:0] act;
      act = (lo + i < log_q.size()) ? 32'(log_q[lo + i]) : 32'hFFFF_FFFF;
      check($sformatf("%s[%0d]", nm, i), act, 32'({exp_tab[elo + i].rs, exp_tab[elo + i].data}));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_start"}, 32'(START_OUT), 0);
    check({nm, "_data"}, 32'(DATA_OUT), 0);
    check({nm, "_rs"}, 32'(RS_OUT), 0);
    check({nm, "_idx"}, 32'(CHAR_IDX), 0);
    check({nm, "_ready"}, 32'(READY), 0);
    check({nm, "_err"}, 32'(ERR_OUT), 0);
  endtask

  task automatic release_rst();
    repeat (2) @(negedge CLK1K);
    log_q.delete();
    rise_q.delete();
    fall_q.delete();
    stab_err = 0;
    RSTN = 1'b1;
    rel = cyc;
  endtask

  task automatic reset_cycle();
    @(negedge CLK1K);
    RSTN = 1'b0;
    release_rst();
  endtask

  task automatic wait_ready(input int lim, input string nm);
    int n = 0;
    while (!READY && n < lim) begin
      @(negedge CLK1K);
      n++;
    end
    check(nm, 32'(READY), 1);
  endtask

  task automatic wait_log(input int cnt, input int lim, input string nm);
    int n = 0;
    while (log_q.size() < cnt && n < lim) begin
      @(negedge CLK1K);
      n++;
    end
    check(nm, 32'(log_q.size() >= cnt), 1);
  endtask

  task automatic pulse_refresh();
    @(negedge CLK1K);
    REFRESH = 1'b1;
    repeat (2) @(negedge CLK1K);
    REFRESH = 1'b0;
    @(negedge CLK1K);
  endtask

  task automatic clear_log();
    log_q.delete();
    rise_q.delete();
    fall_q.delete();
    stab_err = 0;
  endtask

  initial begin
    exp_tab[0] = '{8'h38, 1'b0};
    exp_tab[1] = '{8'h0C, 1'b0};
    exp_tab[2] = '{8'h01, 1'b0};
    exp_tab[3] = '{8'h06, 1'b0};
    exp_tab[4] = '{8'h80, 1'b0};
    for (int i = 0; i < 16; i++) exp_tab[5 + i] = '{8'h41 + 8'(i), 1'b1};
    exp_tab[21] = '{8'hC0, 1'b0};
    for (int i = 0; i < 16; i++) exp_tab[22 + i] = '{8'h51 + 8'(i), 1'b1};
    hold_n = 2;

    // power-up, init and automatic refresh; transfer 2 starts with DONE already high
    repeat (3) @(negedge CLK1K);
    check_reset_outputs("por");
    release_rst();
    @(negedge CLK1K);
    check("pwrup_ready", 32'(READY), 0);
    wait_log(1, 200, "first_start");
    check("pwrup_quiet", 32'(rise_q[0] - rel >= 20), 1);
    wait_ready(2000, "init_ready");
    check("init_count", 32'(log_q.size()), 38);
    cmp(0, 38, 0, "init_seq");
    check("clr_extra_gap", 32'((rise_q[3] - fall_q[2]) - (rise_q[2] - fall_q[1])), 2);
    check("normal_len", 32'(fall_q[0] - rise_q[0]), 19);
    check("held_done_len", 32'(fall_q[1] - rise_q[1]), 19);
    check("init_stable", 32'(stab_err), 0);
    check("idx_wrap", 32'(CHAR_IDX), 0);

    // single refresh from idle
    clear_log();
    pulse_refresh();
    check("refresh_busy", 32'(READY), 0);
    wait_ready(1500, "refresh_ready");
    check("refresh_count", 32'(log_q.size()), 34);
    cmp(0, 34, 4, "refresh_seq");
    check("refresh_stable", 32'(stab_err), 0);

    // three requests during the initial refresh collapse into one extra refresh
    reset_cycle();
    wait_log(10, 1000, "pend_reach");
    pulse_refresh();
    repeat (40) @(negedge CLK1K);
    pulse_refresh();
    repeat (40) @(negedge CLK1K);
    pulse_refresh();
    wait_ready(4000, "pend_ready");
    check("pend_count", 32'(log_q.size()), 72);
    cmp(0, 38, 0, "pend_init");
    cmp(38, 34, 4, "pend_extra");
    repeat (100) @(negedge CLK1K);
    check("pend_no_more", 32'(log_q.size()), 72);

    // reset in the middle of the 10th character, then full replay
    reset_cycle();
    wait_log(15, 1000, "mid_reach");
    repeat (5) @(negedge CLK1K);
    check("mid_start", 32'(START_OUT), 1);
    check("mid_idx", 32'(CHAR_IDX), 9);
    #2 RSTN = 1'b0;
    #1 check_reset_outputs("mid_rst");
    release_rst();
    wait_log(1, 200, "replay_start");
    check("replay_quiet", 32'(rise_q[0] - rel >= 20), 1);
    wait_ready(2000, "replay_ready");
    check("replay_count", 32'(log_q.size()), 38);
    cmp(0, 38, 0, "replay_seq");

    // writer never answers transfer 5: timeout, sticky error, refresh ignored
    skip_n = 5;
    reset_cycle();
    wait_log(5, 1000, "to_reach");
    begin
      int n = 0;
      while (!ERR_OUT && n < 200) begin
        @(negedge CLK1K);
        n++;
      end
    end
    @(negedge CLK1K);
    check("to_err", 32'(ERR_OUT), 1);
    check("to_start", 32'(START_OUT), 0);
    check("to_len", 32'((fall_q.size() > 4) ? fall_q[4] - rise_q[4] : -1), 63);
    pulse_refresh();
    repeat (150) @(negedge CLK1K);
    check("err_ignores_refresh", 32'(log_q.size()), 5);
    check("err_sticky", 32'(ERR_OUT), 1);
    check("err_not_ready", 32'(READY), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_msg_driver.md
LCD_MSG_DRIVER -- requirements
Module: lcd_msg_driver

Interface
REQ-001 Parameter PWRUP_CYCLES, default 20, idle CLK1K cycles after reset before the first command (HD44780 needs 15 ms or more).
REQ-002 Parameter CLR_CYCLES, default 2, extra idle cycles after the clear-display command 0x01.
REQ-003 Parameter TIMEOUT_CYCLES, default 63, maximum cycles to wait for DONE_IN per transfer.
REQ-004 The block SHALL have one clock, CLK1K; reset is RSTN, asynchronous and active-low.
REQ-005 Ports SHALL be:
- CLK1K  in  1  clock, 1 kHz
- RSTN  in  1  async active-low reset
- REFRESH  in  1  level, rising edge requests a 32-char rewrite
- CHAR_DATA  in  8  character at CHAR_IDX, combinational source
- CHAR_IDX  out  5  character index 0..31
- DATA_OUT  out  8  byte to the LCD byte-writer
- RS_OUT  out  1  0 = command, 1 = data
- START_OUT  out  1  transfer request to the writer
- DONE_IN  in  1  writer done flag, rises when a transfer completes
- READY  out  1  idle, no pending work
- ERR_OUT  out  1  sticky timeout flag

Function
REQ-006 The FSM SHALL have the states PWRUP, INIT, CLRWAIT, REFRESH_RUN, IDLE, ERROR.
REQ-007 Each transfer SHALL follow this handshake:
- DATA_OUT/RS_OUT stable one cycle before START_OUT rises.
- START_OUT held high until a DONE_IN rising edge is detected (registered previous-value compare).
- START_OUT then low for at least 1 cycle before the next transfer.
REQ-008 DATA_OUT and RS_OUT SHALL stay constant while START_OUT is high and until the DONE_IN rising edge is seen.
REQ-009 A DONE_IN level that is already high SHALL NOT count as completion; only a 0-to-1 transition after START_OUT rises SHALL complete a transfer.
REQ-010 PWRUP SHALL count PWRUP_CYCLES cycles, then enter INIT.
REQ-011 INIT SHALL issue the commands 0x38, 0x0C, 0x01, 0x06 in order with RS_OUT=0; after 0x01 it SHALL wait CLR_CYCLES in CLRWAIT.
REQ-012 After INIT, the block SHALL automatically run one refresh.
REQ-013 A refresh SHALL issue, in order:
- 0x80 (RS_OUT=0)
- CHAR_IDX 0..15 (RS_OUT=1, DATA_OUT=CHAR_DATA)
- 0xC0 (RS_OUT=0)
- CHAR_IDX 16..31 (RS_OUT=1)
This is 34 transfers in total.
REQ-014 CHAR_DATA SHALL be captured into DATA_OUT one cycle before START_OUT rises; later changes to CHAR_DATA SHALL be ignored for that transfer.
REQ-015 READY SHALL be 1 only in IDLE with no pending refresh.
REQ-016 A REFRESH rising edge in IDLE SHALL start a refresh on the next cycle; INIT SHALL NOT be repeated.
REQ-017 A REFRESH rising edge in PWRUP/INIT/CLRWAIT/REFRESH_RUN SHALL set a single pending flag; multiple edges SHALL collapse to one.
REQ-018 The pending flag SHALL trigger one refresh immediately after the current sequence ends.
REQ-019 The timeout counter SHALL reset at each START_OUT rise.
REQ-020 If TIMEOUT_CYCLES elapse without a DONE_IN rising edge:
- START_OUT goes to 0.
- ERR_OUT goes to 1.
- The FSM enters ERROR.
REQ-021 ERROR SHALL ignore REFRESH and hold until reset.
REQ-022 CHAR_IDX SHALL wrap from 31 to 0 at the end of each refresh.

Reset
REQ-023 Asserting RSTN low SHALL force, at any time including mid-transfer:
- FSM to PWRUP
- all counters to 0
- DATA_OUT=0x00, RS_OUT=0, START_OUT=0, CHAR_IDX=0
- READY=0, ERR_OUT=0
- pending flag cleared, DONE_IN edge register cleared
REQ-024 After RSTN is released, the full PWRUP and INIT sequence SHALL repeat.

Structure
REQ-025 The shared package lcd_pkg SHALL hold:
- command constants 0x38/0x0C/0x01/0x06/0x80/0xC0
- FSM state encoding
- parameter defaults
REQ-026 The handshake, DONE_IN edge detect and timeout SHALL be one sub-module, lcd_xfer (request/byte/rs in; ack/timeout out), instantiated once.

Verification
REQ-027 The bench SHALL pair the block with a writer model that raises DONE 19 cycles after the START rise and clears it on the START edge.
REQ-028 The bench SHALL cover these scenarios:
- Reset release, CHAR_DATA=0x41+idx -> no START_OUT for 20 cycles; then 0x38,0x0C,0x01 (RS=0), 2 idle cycles, 0x06, 0x80, 0x41..0x50 (RS=1), 0xC0, 0x51..0x60; READY=1.
- REFRESH pulse in IDLE -> exactly 34 transfers, no INIT commands, READY back to 1.
- Three REFRESH pulses during the initial refresh -> exactly one additional refresh afterwards.
- Writer model never raises DONE on the 5th transfer -> ERR_OUT=1 and START_OUT=0 63 cycles after START_OUT rises; REFRESH is then ignored.
- DONE_IN held high from an earlier transfer when START_OUT rises -> no completion until DONE_IN falls and rises again.
- RSTN asserted during the 10th character -> all outputs are at reset values immediately; full init replays after release.
